// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 key-expansion sequencer.
// Contents: FSM state encoding, Rcon table (rounds 1..10) with a guarded
// lookup helper, and bit positions of words w0..w3 inside a 128-bit key.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    SUB  = 2'd2
  } ks_state_e;

  // w0 is the most significant word of the key, w3 the least.
  localparam int W0_MSB = 127;
  localparam int W0_LSB = 96;
  localparam int W1_MSB = 95;
  localparam int W1_LSB = 64;
  localparam int W2_MSB = 63;
  localparam int W2_LSB = 32;
  localparam int W3_MSB = 31;
  localparam int W3_LSB = 0;

  // Rcon[1..10]; element 10 is leftmost.
  localparam logic [10:1][7:0] RCON = {
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
  };

  // Round 0 has no Rcon; out-of-range indices return 0 rather than X.
  function automatic logic [7:0] rcon_lookup(input logic [3:0] rnd);
    if (rnd >= 4'd1 && rnd <= 4'd10) begin
      return RCON[rnd];
    end
    return 8'h00;
  endfunction

endpackage

// File: rtl/aes_key_word_next.sv
// Combinational AES-128 next-round-key step; zero latency.
// Inputs: current words w0..w3, substituted RotWord, index of the round being built.
// Outputs: key_next = {n0,n1,n2,n3}; rot_word = RotWord(w3) to send to the S-box.
module aes_key_word_next
  import aes_pkg::*;
#(
  parameter int IDXW = 4
) (
  input  logic [31:0]     w0,
  input  logic [31:0]     w1,
  input  logic [31:0]     w2,
  input  logic [31:0]     w3,
  input  logic [31:0]     sub_word_in,
  input  logic [IDXW-1:0] rnd,
  output logic [127:0]    key_next,
  output logic [31:0]     rot_word
);

  logic [31:0] t;
  logic [31:0] n0;
  logic [31:0] n1;
  logic [31:0] n2;
  logic [31:0] n3;

  always_comb begin
    rot_word = {w3[23:0], w3[31:24]};
    t        = sub_word_in ^ {rcon_lookup(4'(rnd)), 24'h000000};
    // Each new word chains off the previous new word, not the old one.
    n0       = w0 ^ t;
    n1       = w1 ^ n0;
    n2       = w2 ^ n1;
    n3       = w3 ^ n2;
    key_next = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/aes_key_sched.sv
// AES-128 key-expansion sequencer: emits round keys 0..NR over valid/ready,
// borrowing a shared S-box via sub_req/sub_ack for each SubWord.
// Latency: key0 one cycle after start; one key per 2 cycles at full throughput.
// Backpressure: rk_out/rk_idx hold while rk_ready=0; sub_word_out holds until sub_ack.
// Ports: clk/rst_n (sync, active low); start/key_in load a key in IDLE;
//        sub_req/sub_word_out/sub_ack/sub_word_in talk to the S-box;
//        rk_valid/rk_ready/rk_idx/rk_out stream keys; busy, done status.
module aes_key_sched
  import aes_pkg::*;
#(
  parameter int NR   = 10,
  parameter int IDXW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [127:0]    key_in,
  output logic            busy,
  output logic            sub_req,
  output logic [31:0]     sub_word_out,
  input  logic            sub_ack,
  input  logic [31:0]     sub_word_in,
  output logic            rk_valid,
  input  logic            rk_ready,
  output logic [IDXW-1:0] rk_idx,
  output logic [127:0]    rk_out,
  output logic            done
);

  ks_state_e       state_q, state_d;
  logic [127:0]    rk_q, rk_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            done_q, done_d;

  logic [IDXW-1:0] idx_inc;
  logic [127:0]    key_next;
  logic [31:0]     rot_word;

  assign idx_inc = idx_q + IDXW'(1);

  aes_key_word_next #(
    .IDXW (IDXW)
  ) u_word_next (
    .w0          (rk_q[W0_MSB:W0_LSB]),
    .w1          (rk_q[W1_MSB:W1_LSB]),
    .w2          (rk_q[W2_MSB:W2_LSB]),
    .w3          (rk_q[W3_MSB:W3_LSB]),
    .sub_word_in (sub_word_in),
    .rnd         (idx_inc),
    .key_next    (key_next),
    .rot_word    (rot_word)
  );

  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          rk_d    = key_in;
          idx_d   = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (idx_q == IDXW'(NR)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = SUB;
          end
        end
      end
      SUB: begin
        if (sub_ack) begin
          rk_d    = key_next;
          idx_d   = idx_inc;
          state_d = EMIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rk_q    <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // sub_req and rk_valid decode from mutually exclusive states, so they never overlap.
  assign busy         = (state_q != IDLE);
  assign rk_valid     = (state_q == EMIT);
  assign sub_req      = (state_q == SUB);
  assign sub_word_out = sub_req ? rot_word : 32'h0;
  assign rk_idx       = idx_q;
  assign rk_out       = rk_q;
  assign done         = done_q;

endmodule

// File: tb/tb_aes_key_sched.sv
module tb_aes_key_sched;

  localparam int NR   = 10;
  localparam int IDXW = 4;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [127:0]    key_in;
  logic            busy;
  logic            sub_req;
  logic [31:0]     sub_word_out;
  logic            sub_ack;
  logic [31:0]     sub_word_in;
  logic            rk_valid;
  logic            rk_ready;
  logic [IDXW-1:0] rk_idx;
  logic [127:0]    rk_out;
  logic            done;

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] key;
  } exp_t;

  exp_t         sb_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [7:0]   sbox_t [256];
  logic [127:0] acc [0:10];
  logic [127:0] last_acc = '0;
  logic [31:0]  first_sub = '0;
  bit           have_first = 1'b0;
  int           ack_delay = 0;
  int           wcnt = 0;
  bit           rand_rdy = 1'b0;
  int           cyc;

  aes_key_sched #(.NR(NR), .IDXW(IDXW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .key_in       (key_in),
    .busy         (busy),
    .sub_req      (sub_req),
    .sub_word_out (sub_word_out),
    .sub_ack      (sub_ack),
    .sub_word_in  (sub_word_in),
    .rk_valid     (rk_valid),
    .rk_ready     (rk_ready),
    .rk_idx       (rk_idx),
    .rk_out       (rk_out),
    .done         (done)
  );

  always #5 clk = ~clk;

  // ---------------- reference models ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_w(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [127:0] ref_rk(input logic [127:0] key, input int r);
    logic [31:0] w [4];
    logic [31:0] t;
    logic [7:0]  rc;
    w[0] = key[127:96];
    w[1] = key[95:64];
    w[2] = key[63:32];
    w[3] = key[31:0];
    rc   = 8'h01;
    for (int i = 1; i <= r; i++) begin
      t    = sub_w({w[3][23:0], w[3][31:24]}) ^ {rc, 24'h0};
      w[0] = w[0] ^ t;
      w[1] = w[1] ^ w[0];
      w[2] = w[2] ^ w[1];
      w[3] = w[3] ^ w[2];
      rc   = (rc << 1) ^ (rc[7] ? 8'h1b : 8'h00);
    end
    return {w[0], w[1], w[2], w[3]};
  endfunction

  // ---------------- behavioural shared S-box ----------------
  assign sub_ack     = sub_req && (wcnt >= ack_delay);
  assign sub_word_in = sub_w(sub_word_out);

  always @(posedge clk) begin
    if (sub_req && !sub_ack) wcnt <= wcnt + 1;
    else                     wcnt <= 0;
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},     160'(busy),         160'(0));
    chk({tag, "_sub_req"},  160'(sub_req),      160'(0));
    chk({tag, "_rk_valid"}, 160'(rk_valid),     160'(0));
    chk({tag, "_done"},     160'(done),         160'(0));
    chk({tag, "_rk_idx"},   160'(rk_idx),       160'(0));
    chk({tag, "_rk_out"},   160'(rk_out),       160'(0));
    chk({tag, "_sub_word"}, 160'(sub_word_out), 160'(0));
  endtask

  // Monitor: scoreboard pops on handshake, hold/overlap/RotWord checks.
  logic [127:0] p_key = '0;
  logic [3:0]   p_idx = '0;
  logic [31:0]  p_sub = '0;
  bit           p_vwait = 1'b0;
  bit           p_swait = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      chk("no_overlap", 160'(sub_req & rk_valid), 160'(0));
      if (p_vwait) chk("rk_hold", 160'({rk_valid, rk_idx, rk_out}), 160'({1'b1, p_idx, p_key}));
      if (p_swait) chk("sub_hold", 160'({sub_req, sub_word_out}), 160'({1'b1, p_sub}));
      if (sub_req) begin
        chk("sub_word", 160'(sub_word_out), 160'({last_acc[23:0], last_acc[31:24]}));
        if (!have_first) begin
          first_sub  = sub_word_out;
          have_first = 1'b1;
        end
      end
      if (rk_valid && rk_ready) begin
        chk("sb_nonempty", 160'(sb_q.size() > 0), 160'(1));
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("sb_rk_idx", 160'(rk_idx), 160'(e.idx));
          chk("sb_rk_out", 160'(rk_out), 160'(e.key));
        end
        if (rk_idx <= 4'd10) acc[rk_idx] = rk_out;
        last_acc = rk_out;
      end
    end
    p_vwait = (rst_n === 1'b1) && rk_valid && !rk_ready;
    p_swait = (rst_n === 1'b1) && sub_req && !sub_ack;
    p_key   = rk_out;
    p_idx   = rk_idx;
    p_sub   = sub_word_out;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) rk_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic start_key(input logic [127:0] k);
    exp_t e;
    for (int i = 0; i <= NR; i++) begin
      e.idx = 4'(i);
      e.key = ref_rk(k, i);
      sb_q.push_back(e);
    end
    for (int i = 0; i <= NR; i++) acc[i] = 'x;
    have_first = 1'b0;
    key_in = k;
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  // Returns the cycle (relative to the start edge) in which done is seen.
  task automatic wait_done(input int budget, input bit pulse, output int c);
    bit pulsed;
    pulsed = 1'b0;
    c = 1;
    while (!done && c < budget) begin
      if (pulse && !pulsed && rk_valid && rk_idx == 4'd4) begin
        start  = 1'b1;
        key_in = ~key_in;
        pulsed = 1'b1;
      end
      step();
      start = 1'b0;
      c++;
    end
    chk("done_seen", 160'(done), 160'(1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] inv;
    rst_n    = 1'b0;
    start    = 1'b0;
    key_in   = '0;
    rk_ready = 1'b1;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++) begin
        if (gf_mul(8'(v), 8'(c)) == 8'h01) inv = 8'(c);
      end
      sbox_t[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

    repeat (3) step();
    chk_zero("reset");
    rst_n = 1'b1;
    step();

    // FIPS-197 key, zero-wait S-box, always ready.
    start_key(FIPS_KEY);
    chk("fips_rk0_valid", 160'(rk_valid), 160'(1));
    chk("fips_rk0_idx",   160'(rk_idx),   160'(0));
    chk("fips_rk0",       160'(rk_out),   160'(FIPS_KEY));
    chk("fips_busy",      160'(busy),     160'(1));
    wait_done(100, 1'b0, cyc);
    chk("fips_done_cycle", 160'(cyc), 160'(22));
    chk("fips_busy_low",   160'(busy), 160'(0));
    chk("fips_sb_drained", 160'(sb_q.size()), 160'(0));
    chk("fips_first_sub",  160'(first_sub), 160'(32'hcf4f3c09));
    chk("fips_rk1",        160'(acc[1]),  160'(FIPS_RK1));
    chk("fips_rk10",       160'(acc[10]), 160'(FIPS_RK10));

    // Restart in the done cycle: no idle gap, no extra done.
    start_key(FIPS_KEY);
    chk("b2b_rk0_valid", 160'(rk_valid), 160'(1));
    chk("b2b_no_done",   160'(done),     160'(0));
    chk("b2b_rk0",       160'(rk_out),   160'(FIPS_KEY));
    wait_done(100, 1'b0, cyc);
    chk("b2b_done_cycle", 160'(cyc), 160'(22));

    // Slow S-box and random consumer backpressure.
    step();
    ack_delay = 3;
    rand_rdy  = 1'b1;
    start_key(FIPS_KEY);
    wait_done(1000, 1'b0, cyc);
    rand_rdy = 1'b0;
    rk_ready = 1'b1;
    chk("bp_sb_drained", 160'(sb_q.size()), 160'(0));
    chk("bp_rk10",       160'(acc[10]), 160'(FIPS_RK10));

    // start pulsed mid-expansion with a different key must be ignored.
    step();
    ack_delay = 0;
    start_key(FIPS_KEY);
    wait_done(100, 1'b1, cyc);
    chk("ign_done_cycle", 160'(cyc), 160'(22));
    chk("ign_rk5",        160'(acc[5]),  160'(ref_rk(FIPS_KEY, 5)));
    chk("ign_rk10",       160'(acc[10]), 160'(FIPS_RK10));
    chk("ign_sb_drained", 160'(sb_q.size()), 160'(0));

    // Reset while SUB for round 6 has its S-box ack still pending.
    step();
    ack_delay = 3;
    start_key(FIPS_KEY);
    cyc = 1;
    while (!(sub_req && rk_idx == 4'd6 && !sub_ack) && cyc < 200) begin
      step();
      cyc++;
    end
    chk("rst_reach_sub6", 160'(sub_req && rk_idx == 4'd6 && !sub_ack), 160'(1));
    rst_n = 1'b0;
    step();
    chk_zero("midrst");
    rst_n = 1'b1;
    sb_q.delete();
    ack_delay = 0;
    step();
    start_key(FIPS_KEY);
    wait_done(100, 1'b0, cyc);
    chk("post_rst_done_cycle", 160'(cyc), 160'(22));
    chk("post_rst_rk1",        160'(acc[1]),  160'(FIPS_RK1));
    chk("post_rst_rk10",       160'(acc[10]), 160'(FIPS_RK10));

    // All-zero key.
    step();
    start_key(128'h0);
    wait_done(100, 1'b0, cyc);
    chk("zero_rk1",  160'(acc[1]),  160'(ZERO_RK1));
    chk("zero_rk10", 160'(acc[10]), 160'(ZERO_RK10));
    chk("zero_sb_drained", 160'(sb_q.size()), 160'(0));

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_key_sched.md
Name: aes_key_sched

Overview:
AES-128 key-expansion sequencer. It sits next to the byte-rotate and ShiftRows datapath and produces round keys 0..10 one at a time over a valid/ready stream, for consumption by the round datapath.
- It owns the RotWord rotation, the Rcon constants and the round counter.
- SubWord is obtained from a shared external S-box unit through a req/ack handshake, so one S-box serves both the key schedule and the datapath.

Parameters:
NR, 10, number of expansion rounds (AES-128); rk_idx runs 0..NR.
IDXW, 4, width of rk_idx.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  begin expansion of key_in; sampled only in IDLE
key_in  in  128  cipher key; [127:96]=w0 ... [31:0]=w3
busy  out  1  high while state != IDLE
sub_req  out  1  SubWord request to shared S-box
sub_word_out  out  32  word to substitute; valid while sub_req
sub_ack  in  1  S-box result valid; may be high in the same cycle sub_req rises
sub_word_in  in  32  substituted word; sampled when sub_req && sub_ack
rk_valid  out  1  round key available
rk_ready  in  1  consumer accepts round key
rk_idx  out  IDXW  round index of rk_out
rk_out  out  128  current round key
done  out  1  one-cycle pulse after round key NR is accepted

Behaviour:
- Reset (rst_n=0 at clk edge, any state, including mid-expansion):
  - state=IDLE, counter=0.
  - busy=0, sub_req=0, rk_valid=0, done=0, rk_idx=0, rk_out=0.
  - sub_word_out=0; it is driven only while sub_req, else 0.
  - A pending S-box transaction is abandoned.
- States: IDLE, EMIT, SUB.
- IDLE:
  - On start=1: rk_out<=key_in, rk_idx<=0, go EMIT.
  - start is ignored in EMIT and SUB.
- EMIT:
  - rk_valid=1; rk_out and rk_idx are held stable until rk_ready.
  - On rk_ready with rk_idx==NR: go IDLE, done<=1 for exactly one cycle.
  - On rk_ready with rk_idx<NR: go SUB.
- SUB:
  - sub_req=1; sub_word_out=RotWord(w3)={w3[23:0],w3[31:24]}, i.e. rotate left one byte.
  - sub_word_out is held stable until ack.
  - On sub_ack:
    - t = sub_word_in ^ {Rcon[rk_idx+1],24'h0}
    - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2
    - rk_out<={n0,n1,n2,n3}, rk_idx<=rk_idx+1, go EMIT.
- Never both sub_req and rk_valid high in the same cycle.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- All XOR arithmetic is 32-bit with no carries; rk_idx never wraps past NR.
- Latency: with rk_ready=1 and sub_ack=1 held constantly:
  - start sampled at edge E0 -> rk_valid for idx0 in cycle E0+1.
  - Each further key every 2 cycles; idx10 in cycle E0+21.
  - done=1 and busy=0 in cycle E0+22.
- busy: high from the cycle after start through the last EMIT cycle; low in the done cycle.
- start in the same cycle as done (state is IDLE) is accepted.

Decomposition:
- Shared package aes_pkg: state enum (IDLE/EMIT/SUB), the Rcon constant array indexed 1..10, and the word-order constants for w0..w3 slicing.
- Sub-module aes_key_word_next: purely combinational.
  - Inputs: w0..w3, sub_word_in, round index.
  - Outputs: next 128-bit key and the RotWord value.
- The top module holds the FSM and registers.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, behavioural S-box with zero-wait ack, rk_ready=1 -> all of:
  - rk0 = key; first sub_word_out = cf4f3c09.
  - rk1 = a0fafe17_88542cb1_23a33939_2a6c7605.
  - rk10 = d014f9a8_c9ee2589_e13f0cc8_b6630ca6.
  - done in cycle E0+22.
- Same key, S-box ack delayed 3 cycles and rk_ready randomly deasserted -> identical 11 keys in order; sub_word_out and rk_out stable while waiting; sub_req and rk_valid never overlap.
- start pulsed while busy (at idx 4) with a different key_in -> ignored; the sequence completes with the original key's rk5..rk10.
- rst_n=0 during SUB (idx 6, ack pending) -> next cycle all outputs 0, state IDLE; a fresh start reproduces rk0..rk10 correctly.
- All-zero key -> rk1 = 62636363_62636363_62636363_62636363; rk10 = b4ef5bcb_3e92e211_23e951cf_6f8f188e.
- start asserted in the done cycle -> new rk0 valid in the next cycle, with no idle gap and no extra done.
